// File: rtl/fewcore_pkg.sv
// fewcore_pkg
// Shared defaults and types for the forwarding scoreboard.
//   REG_AW_DEF, STAGES_DEF, LOAD_EXTRA_DEF : default geometry
//   RD_MAX_W                               : register-address field width in an entry
//   FWD_REGFILE                            : forward-select code meaning "use register file"
//   sb_entry_t                             : one pipeline position {valid, rd, is_load}
package fewcore_pkg;

    localparam int REG_AW_DEF     = 5;
    localparam int STAGES_DEF     = 3;
    localparam int LOAD_EXTRA_DEF = 1;

    // Entries carry a fixed-width rd field so the struct can live here;
    // REG_AW must not exceed this width.
    localparam int RD_MAX_W = 8;

    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// sb_match
// Priority matcher for one source operand. Finds the youngest in-flight
// entry writing rs and reports whether it can be forwarded yet.
//   entries : shift-array contents, index 0 youngest
//   rs      : source register
//   req     : youngest match is a load not yet forwardable (stall request)
//   sel     : 0 = register file, k = forward from position k-1
module sb_match
    import fewcore_pkg::*;
#(
    parameter  int REG_AW     = REG_AW_DEF,
    parameter  int STAGES     = STAGES_DEF,
    parameter  int LOAD_EXTRA = LOAD_EXTRA_DEF,
    localparam int SW         = $clog2(STAGES + 1)
) (
    input  sb_entry_t [STAGES-1:0] entries,
    input  logic [REG_AW-1:0]      rs,
    output logic                   req,
    output logic [SW-1:0]          sel
);

    // Walk oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        req = 1'b0;
        sel = SW'(FWD_REGFILE);
        for (int p = STAGES - 1; p >= 0; p--) begin
            if (entries[p].valid && (entries[p].rd == RD_MAX_W'(rs)) && (rs != '0)) begin
                if (!entries[p].is_load || (p >= LOAD_EXTRA)) begin
                    req = 1'b0;
                    sel = SW'(p + 1);
                end else begin
                    req = 1'b1;
                    sel = SW'(FWD_REGFILE);
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_fwd.sv
// scoreboard_fwd
// Tracks destination registers of in-flight instructions in a shift array
// and produces operand forward selects plus a load-use stall for decode.
//   clk, reset            : clock, async active-high reset
//   issue_valid/rd/we     : instruction presented by decode and its destination
//   issue_is_load         : instruction is a load (result arrives late)
//   issue_rs1/rs2         : source registers
//   flush                 : taken branch, current issue discarded
//   stall                 : hold decode this cycle
//   fwd_sel_rs1/rs2       : 0 = register file, k = forward from position k-1
//   inflight              : number of valid entries
//   stall_count           : saturating count of stall cycles
module scoreboard_fwd
    import fewcore_pkg::*;
#(
    parameter  int REG_AW     = REG_AW_DEF,
    parameter  int STAGES     = STAGES_DEF,
    parameter  int LOAD_EXTRA = LOAD_EXTRA_DEF,
    localparam int SW         = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    input  logic              issue_is_load,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic              flush,
    output logic              stall,
    output logic [SW-1:0]     fwd_sel_rs1,
    output logic [SW-1:0]     fwd_sel_rs2,
    output logic [SW-1:0]     inflight,
    output logic [31:0]       stall_count
);

    sb_entry_t [STAGES-1:0] entries_q;
    sb_entry_t              issue_entry;
    logic                   req_rs1;
    logic                   req_rs2;
    logic                   accept;
    logic [31:0]            stall_cnt_q;

    sb_match #(
        .REG_AW     (REG_AW),
        .STAGES     (STAGES),
        .LOAD_EXTRA (LOAD_EXTRA)
    ) u_match_rs1 (
        .entries (entries_q),
        .rs      (issue_rs1),
        .req     (req_rs1),
        .sel     (fwd_sel_rs1)
    );

    sb_match #(
        .REG_AW     (REG_AW),
        .STAGES     (STAGES),
        .LOAD_EXTRA (LOAD_EXTRA)
    ) u_match_rs2 (
        .entries (entries_q),
        .rs      (issue_rs2),
        .req     (req_rs2),
        .sel     (fwd_sel_rs2)
    );

    assign stall  = issue_valid & ~flush & ~reset & (req_rs1 | req_rs2);
    assign accept = issue_valid & ~stall & ~flush;

    // Writes to x0 never become valid entries, so x0 can never match.
    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = issue_we & (issue_rd != '0);
        issue_entry.rd      = RD_MAX_W'(issue_rd);
        issue_entry.is_load = issue_is_load;
    end

    // Unconditional shift: a stalled consumer is released as the load ages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
        end else begin
            entries_q[0] <= accept ? issue_entry : '0;
            for (int p = 1; p < STAGES; p++) begin
                entries_q[p] <= entries_q[p-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;

    always_comb begin
        inflight = '0;
        for (int p = 0; p < STAGES; p++) begin
            inflight = inflight + SW'(entries_q[p].valid);
        end
    end

endmodule
